// File: rtl/perf_event_dump.sv
// perf_event_dump: saturating per-event counters with a periodic or requested
// snapshot that is streamed out as (id, count) beats over a valid/ready port.
// Debug/difftest infrastructure only.
module perf_event_dump #(
  parameter int EVENT_NUM     = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int DUMP_INTERVAL = 1024,
  parameter int ID_WIDTH      = (EVENT_NUM > 1) ? $clog2(EVENT_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] events,
  input  logic                 dump_req,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_last,
  output logic                 busy,
  output logic [7:0]           dropped
);

  localparam int IC_W = (DUMP_INTERVAL > 1) ? $clog2(DUMP_INTERVAL) : 1;
  localparam logic [IC_W-1:0] IC_LAST = IC_W'((DUMP_INTERVAL > 0) ? DUMP_INTERVAL - 1 : 0);
  localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(EVENT_NUM - 1);
  localparam logic PERIODIC_EN = (DUMP_INTERVAL != 0);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t               state;
  state_t               stateNext;
  logic [CNT_WIDTH-1:0] cnt  [EVENT_NUM];
  logic [CNT_WIDTH-1:0] snap [EVENT_NUM];
  logic [IC_W-1:0]      ic;
  logic [ID_WIDTH-1:0]  idx;
  logic                 pend;
  logic                 periodic;
  logic                 trigger;
  logic                 startDump;
  logic                 handshake;
  logic                 lastBeat;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] satIncCnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] satIncDrop(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  assign periodic  = PERIODIC_EN && (ic == IC_LAST);
  assign trigger   = periodic || dump_req;
  assign startDump = (state == IDLE) && (trigger || pend);
  assign handshake = (state == DUMP) && out_ready;
  assign lastBeat  = (idx == ID_LAST);

  // Interval counter: free-runs 0..DUMP_INTERVAL-1, parked at 0 when periodic dumps are off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic <= '0;
    end else if (clear || !PERIODIC_EN || (ic == IC_LAST)) begin
      ic <= '0;
    end else begin
      ic <= ic + 1'b1;
    end
  end

  // Live event counters; clear beats a same-cycle event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EVENT_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < EVENT_NUM; i++) begin
        if (clear) begin
          cnt[i] <= '0;
        end else if (events[i]) begin
          cnt[i] <= satIncCnt(cnt[i]);
        end
      end
    end
  end

  // Snapshot captures the counters as they stood before this cycle's events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EVENT_NUM; i++) snap[i] <= '0;
    end else if (startDump) begin
      for (int i = 0; i < EVENT_NUM; i++) snap[i] <= cnt[i];
    end
  end

  // Beat index, one-deep pending trigger, and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      pend    <= 1'b0;
      dropped <= '0;
    end else if (startDump) begin
      idx  <= '0;
      pend <= 1'b0;
    end else if (state == DUMP) begin
      if (handshake && !lastBeat) begin
        idx <= idx + 1'b1;
      end
      if (trigger) begin
        if (!pend) begin
          pend <= 1'b1;
        end else begin
          dropped <= satIncDrop(dropped);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state: a dump always returns through IDLE, forcing an idle gap.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startDump) stateNext = DUMP;
      DUMP:    if (handshake && lastBeat) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Beat outputs come straight from registers; the payload is zero outside a dump.
  always_comb begin
    busy      = (state == DUMP);
    out_valid = busy;
    out_id    = busy ? idx : '0;
    out_count = busy ? snap[idx] : '0;
    out_last  = busy && lastBeat;
  end

endmodule

// File: tb/tb_perf_event_dump.sv
// Randomized and directed bench for perf_event_dump against a queue-based model.
module tb_perf_event_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  events = '0;
  logic        dump_req = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [3:0]  out_count;
  logic        out_last;
  logic        busy;
  logic [7:0]  dropped;

  logic [7:0]  idleEvents = '0;
  logic        idleReq = 1'b0;
  logic        idleClear = 1'b0;
  logic        idleReady = 1'b1;
  logic        idleValid;
  logic [2:0]  idleId;
  logic [31:0] idleCount;
  logic        idleLast;
  logic        idleBusy;
  logic [7:0]  idleDropped;

  perf_event_dump #(.EVENT_NUM(4), .CNT_WIDTH(4), .DUMP_INTERVAL(16)) dut (
    .clk(clk), .rst(rst), .events(events), .dump_req(dump_req), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_count(out_count), .out_last(out_last), .busy(busy), .dropped(dropped)
  );

  perf_event_dump #(.EVENT_NUM(8), .CNT_WIDTH(32), .DUMP_INTERVAL(0)) idleDut (
    .clk(clk), .rst(rst), .events(idleEvents), .dump_req(idleReq), .clear(idleClear),
    .out_valid(idleValid), .out_ready(idleReady), .out_id(idleId),
    .out_count(idleCount), .out_last(idleLast), .busy(idleBusy), .dropped(idleDropped)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  int idleChecks = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a dump is a queue of pending beats, filled in one go.
  typedef struct packed { int id; int cnt; } beat_t;
  beat_t mq[$];
  int    mCnt[4];
  int    mIc;
  bit    mPend;
  int    mDropped;

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < 4; i++) mCnt[i] = 0;
    mIc = 0;
    mPend = 0;
    mDropped = 0;
  endtask

  task automatic modelStep(input logic [3:0] ev, input logic req, input logic clr, input logic rdy);
    bit trig;
    trig = (mIc == 15) || req;
    if (mq.size() > 0) begin
      if (trig) begin
        if (!mPend) mPend = 1;
        else if (mDropped < 255) mDropped++;
      end
      if (rdy) void'(mq.pop_front());
    end else if (trig || mPend) begin
      for (int i = 0; i < 4; i++) mq.push_back('{id: i, cnt: mCnt[i]});
      mPend = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (clr) mCnt[i] = 0;
      else if (ev[i] && mCnt[i] < 15) mCnt[i]++;
    end
    mIc = clr ? 0 : (mIc + 1) % 16;
  endtask

  task automatic compareAll();
    bit v;
    int eId;
    int eCnt;
    v = (mq.size() > 0);
    eId = 0;
    eCnt = 0;
    if (v) begin
      eId = mq[0].id;
      eCnt = mq[0].cnt;
    end
    checkVal("valid", 64'(out_valid), 64'(v));
    checkVal("busy", 64'(busy), 64'(v));
    checkVal("id", 64'(out_id), 64'(eId));
    checkVal("count", 64'(out_count), 64'(eCnt));
    checkVal("last", 64'(out_last), 64'(v && eId == 3));
    checkVal("dropped", 64'(dropped), 64'(mDropped));
    if (idleChecks < 100) begin
      idleChecks++;
      checkVal("idle_valid", 64'(idleValid), 64'(0));
      checkVal("idle_busy", 64'(idleBusy), 64'(0));
      checkVal("idle_dropped", 64'(idleDropped), 64'(0));
    end
  endtask

  // Called at a falling edge: drive inputs, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic tick(input logic [3:0] ev, input logic req, input logic clr, input logic rdy);
    events = ev;
    dump_req = req;
    clear = clr;
    out_ready = rdy;
    idleEvents = 8'($urandom);
    @(posedge clk);
    modelStep(ev, req, clr, rdy);
    @(negedge clk);
    compareAll();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() > 0 || mPend) && n < 100) begin
      tick(4'd0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    checkVal("drain_busy", 64'(busy), 64'(0));
  endtask

  task automatic quietClear();
    for (int a = 0; a < 4; a++) begin
      drain();
      tick(4'd0, 1'b0, 1'b1, 1'b1);
      if (mq.size() == 0 && !mPend) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int expBp[4];
    int got[4];
    int hs;
    bit lastSeen;
    int dB;
    int periodicCnt[4];

    expBp = '{7, 3, 0, 9};
    periodicCnt = '{15, 0, 15, 0};
    modelReset();

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("rst_valid", 64'(out_valid), 64'(0));
    checkVal("rst_busy", 64'(busy), 64'(0));
    checkVal("rst_id", 64'(out_id), 64'(0));
    checkVal("rst_count", 64'(out_count), 64'(0));
    checkVal("rst_last", 64'(out_last), 64'(0));
    checkVal("rst_dropped", 64'(dropped), 64'(0));
    rst = 1'b1;

    // Periodic dump from reset release, events 0101 every cycle
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0101, 1'b0, 1'b0, 1'b1);
      if (k < 16) begin
        checkVal("per_quiet", 64'(out_valid), 64'(0));
      end else if (k < 20) begin
        checkVal("per_valid", 64'(out_valid), 64'(1));
        checkVal("per_id", 64'(out_id), 64'(k - 16));
        checkVal("per_count", 64'(out_count), 64'(periodicCnt[k - 16]));
        checkVal("per_last", 64'(out_last), 64'(k == 19));
      end else begin
        checkVal("per_done", 64'(out_valid), 64'(0));
      end
    end

    // Backpressure with counts {7,3,0,9}
    quietClear();
    for (int k = 0; k < 9; k++) tick({1'b1, 1'b0, k < 3, k < 7}, 1'b0, 1'b0, 1'b1);
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    hs = 0;
    lastSeen = 0;
    for (int k = 0; k < 40 && hs < 4; k++) begin
      logic rdy;
      rdy = k[0];
      if (out_valid && rdy) begin
        got[hs] = int'(out_count);
        lastSeen = out_last;
        hs++;
      end
      tick(4'd0, 1'b0, 1'b0, rdy);
    end
    checkVal("bp_handshakes", 64'(hs), 64'(4));
    for (int i = 0; i < 4; i++) checkVal("bp_beat", 64'(got[i]), 64'(expBp[i]));
    checkVal("bp_last", 64'(lastSeen), 64'(1));

    // Pending and drop
    quietClear();
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    dB = mDropped;
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    checkVal("pend_dropped", 64'(dropped), 64'(dB + 1));
    for (int n = 0; n < 20; n++) begin
      if (out_valid && out_last) begin
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        break;
      end
      tick(4'd0, 1'b0, 1'b0, 1'b1);
    end
    checkVal("gap_idle", 64'(out_valid), 64'(0));
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    checkVal("second_valid", 64'(out_valid), 64'(1));
    checkVal("second_id", 64'(out_id), 64'(0));

    // Saturation, then clear beating a same-cycle event
    quietClear();
    for (int k = 0; k < 20; k++) tick(4'b0001, 1'b0, 1'b0, 1'b1);
    drain();
    tick(4'd0, 1'b1, 1'b0, 1'b1);
    checkVal("sat_id", 64'(out_id), 64'(0));
    checkVal("sat_count", 64'(out_count), 64'(15));
    drain();
    tick(4'b0001, 1'b0, 1'b1, 1'b1);
    drain();
    tick(4'd0, 1'b1, 1'b0, 1'b1);
    checkVal("clr_id", 64'(out_id), 64'(0));
    checkVal("clr_count", 64'(out_count), 64'(0));

    // Reset during beat id 2
    quietClear();
    tick(4'b1111, 1'b1, 1'b0, 1'b1);
    tick(4'b1111, 1'b0, 1'b0, 1'b1);
    tick(4'b1111, 1'b0, 1'b0, 1'b1);
    checkVal("pre_rst_id", 64'(out_id), 64'(2));
    #1 rst = 1'b0;
    #1;
    checkVal("mid_rst_valid", 64'(out_valid), 64'(0));
    checkVal("mid_rst_busy", 64'(busy), 64'(0));
    checkVal("mid_rst_id", 64'(out_id), 64'(0));
    checkVal("mid_rst_count", 64'(out_count), 64'(0));
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick(4'd0, 1'b1, 1'b0, 1'b1);
    checkVal("post_rst_id", 64'(out_id), 64'(0));
    for (int i = 0; i < 4; i++) begin
      checkVal("post_rst_count", 64'(out_count), 64'(0));
      tick(4'd0, 1'b0, 1'b0, 1'b1);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      tick(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
